// File: rtl/ysyx_22050078_fetch_ctrl.sv
// Instruction fetch controller: REQ/WAIT/HOLD handshake between the I-memory and the IDU, with redirects.
// Optional misaligned-fetch trap enabled by defining YSYX_22050078_FETCH_ALIGN_CHK_EN.
module ysyx_22050078_fetch_ctrl #(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_valid,
    output logic [PC_WIDTH-1:0]   req_addr,
    input  logic                  req_ready,
    input  logic                  resp_valid,
    input  logic [INST_WIDTH-1:0] resp_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   pc,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  fault
);

`ifdef YSYX_22050078_FETCH_ALIGN_CHK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic                    drop_q, drop_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [PC_WIDTH-1:0]     inst_pc_q, inst_pc_d;
    logic                    fault_q, fault_d;
    logic                    req_valid_q, req_valid_d;
    logic                    inst_valid_q, inst_valid_d;

    function automatic logic misaligned(input logic [1:0] lsb);
        misaligned = ALIGN_EN && (lsb != 2'b00);
    endfunction

    // Next-state logic: redirect outranks every other event in every state
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (req_valid_q && req_ready) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    // A late response seen here is the stale one the drop flag was waiting for.
                    if (resp_valid && drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        drop_d = drop_q;
                    end
                    if (misaligned(pc_q[1:0])) begin
                        inst_d    = '0;
                        inst_pc_d = pc_q;
                        fault_d   = 1'b1;
                        state_d   = S_HOLD;
                    end else if (req_ready) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    drop_d  = !resp_valid;
                    state_d = S_REQ;
                end else if (resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = resp_data;
                        inst_pc_d = pc_q;
                        fault_d   = 1'b0;
                        state_d   = S_HOLD;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        req_valid_d  = (state_d == S_REQ) && !misaligned(pc_d[1:0]);
        inst_valid_d = (state_d == S_HOLD);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
            req_valid_q  <= !misaligned(RESET_PC[1:0]);
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign pc         = inst_pc_q;
    assign fault      = ALIGN_EN ? fault_q : 1'b0;

endmodule

// File: tb/tb_ysyx_22050078_fetch_ctrl.sv
// Self-checking bench for ysyx_22050078_fetch_ctrl: directed vector table, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_ysyx_22050078_fetch_ctrl;

`ifdef YSYX_22050078_FETCH_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        fault;

    int n_pass = 0;
    int n_total = 0;

    ysyx_22050078_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .inst_valid(inst_valid), .inst(inst), .pc(pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model: is a fetch outstanding, is an instruction held, must the next response be discarded
    logic [63:0] m_pc;
    bit          m_busy, m_held, m_drop, m_fault;
    logic [31:0] m_inst;
    logic [63:0] m_ipc;

    function automatic void model_reset();
        m_pc = RST_PC; m_busy = 0; m_held = 0; m_drop = 0; m_fault = 0; m_inst = 32'h0; m_ipc = 64'h0;
    endfunction

    function automatic bit m_bad_align();
        return ALIGN && (m_pc[1:0] != 2'b00);
    endfunction

    function automatic bit m_req_valid();
        return !m_busy && !m_held && !m_bad_align();
    endfunction

    function automatic void model_step(bit rd, logic [63:0] rp, bit ry, bit rs, logic [31:0] d, bit ir);
        if (rd) begin
            if (m_held) m_held = 0;
            else if (m_busy) begin m_busy = 0; m_drop = !rs; end
            else if (m_req_valid() && ry) begin m_busy = 1; m_drop = 1; end
            m_pc = rp;
        end else if (m_held) begin
            if (ir) begin m_held = 0; m_pc = m_pc + 64'd4; end
        end else if (m_busy) begin
            if (rs) begin
                m_busy = 0;
                if (m_drop) m_drop = 0;
                else begin m_held = 1; m_inst = d; m_ipc = m_pc; m_fault = 0; end
            end
        end else begin
            if (rs) m_drop = 0;
            if (m_bad_align()) begin m_held = 1; m_inst = 32'h0; m_ipc = m_pc; m_fault = 1; end
            else if (ry) m_busy = 1;
        end
    endfunction

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endfunction

    task automatic expect_out(string nm, bit rv, logic [63:0] a, bit iv, logic [31:0] i,
                              logic [63:0] p, bit f);
        chk({nm, ".req_valid"}, {63'd0, req_valid}, {63'd0, rv});
        chk({nm, ".req_addr"}, req_addr, a);
        chk({nm, ".inst_valid"}, {63'd0, inst_valid}, {63'd0, iv});
        chk({nm, ".inst"}, {32'd0, inst}, {32'd0, i});
        chk({nm, ".pc"}, pc, p);
        chk({nm, ".fault"}, {63'd0, fault}, {63'd0, f});
    endtask

    task automatic step(bit rd, logic [63:0] rp, bit ry, bit rs, logic [31:0] d, bit ir);
        redirect_valid = rd; redirect_pc = rp; req_ready = ry;
        resp_valid = rs; resp_data = d; inst_ready = ir;
        model_step(rd, rp, ry, rs, d, ir);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 0; req_ready = 0; resp_valid = 0; inst_ready = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic        rd;
        logic [63:0] rp;
        logic        ry;
        logic        rs;
        logic [31:0] d;
        logic        ir;
        logic        erv;
        logic [63:0] ea;
        logic        eiv;
        logic [31:0] ei;
        logic [63:0] ep;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(bit rd, logic [63:0] rp, bit ry, bit rs, logic [31:0] d, bit ir,
                                 bit erv, logic [63:0] ea, bit eiv, logic [31:0] ei, logic [63:0] ep);
        tbl.push_back('{rd, rp, ry, rs, d, ir, erv, ea, eiv, ei, ep});
    endfunction

    initial begin
        // rd rp ry rs data ir | req_valid req_addr inst_valid inst pc
        addv(0, 0, 1, 0, 32'h0,        0, 0, 64'h8000_0000, 0, 32'h0,        64'h0);
        addv(0, 0, 0, 1, 32'h0000_0413, 0, 0, 64'h8000_0000, 1, 32'h0000_0413, 64'h8000_0000);
        for (int k = 0; k < 5; k++)
            addv(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 64'h8000_0000, 1, 32'h0000_0413, 64'h8000_0000);
        addv(0, 0, 0, 0, 32'h0,        1, 1, 64'h8000_0004, 0, 32'h0000_0413, 64'h8000_0000);
        addv(0, 0, 1, 0, 32'h0,        0, 0, 64'h8000_0004, 0, 32'h0000_0413, 64'h8000_0000);
        addv(1, 64'h8000_0100, 0, 0, 32'h0, 0, 1, 64'h8000_0100, 0, 32'h0000_0413, 64'h8000_0000);
        addv(0, 0, 0, 1, 32'hDEAD_0001, 0, 1, 64'h8000_0100, 0, 32'h0000_0413, 64'h8000_0000);
        addv(0, 0, 1, 0, 32'h0,        0, 0, 64'h8000_0100, 0, 32'h0000_0413, 64'h8000_0000);
        addv(0, 0, 0, 1, 32'h0010_0093, 0, 0, 64'h8000_0100, 1, 32'h0010_0093, 64'h8000_0100);
        addv(1, 64'h8000_0200, 0, 0, 32'h0, 1, 1, 64'h8000_0200, 0, 32'h0010_0093, 64'h8000_0100);
        addv(1, 64'h8000_0300, 1, 0, 32'h0, 0, 0, 64'h8000_0300, 0, 32'h0010_0093, 64'h8000_0100);
        addv(0, 0, 0, 1, 32'h0000_AAAA, 0, 1, 64'h8000_0300, 0, 32'h0010_0093, 64'h8000_0100);
        addv(0, 0, 1, 0, 32'h0,        0, 0, 64'h8000_0300, 0, 32'h0010_0093, 64'h8000_0100);
        addv(0, 0, 0, 1, 32'h0000_0013, 0, 0, 64'h8000_0300, 1, 32'h0000_0013, 64'h8000_0300);
        addv(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0000_0013, 64'h8000_0300);
        addv(0, 0, 1, 0, 32'h0,        0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0000_0013, 64'h8000_0300);
        addv(0, 0, 0, 1, 32'h0000_0073, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0000_0073, 64'hFFFF_FFFF_FFFF_FFFC);
        addv(0, 0, 0, 0, 32'h0,        1, 1, 64'h0,           0, 32'h0000_0073, 64'hFFFF_FFFF_FFFF_FFFC);
        addv(0, 0, 1, 0, 32'h0,        0, 0, 64'h0,           0, 32'h0000_0073, 64'hFFFF_FFFF_FFFF_FFFC);
        addv(1, 64'h8000_0400, 0, 1, 32'h0000_BBBB, 0, 1, 64'h8000_0400, 0, 32'h0000_0073, 64'hFFFF_FFFF_FFFF_FFFC);
        addv(0, 0, 1, 0, 32'h0,        0, 0, 64'h8000_0400, 0, 32'h0000_0073, 64'hFFFF_FFFF_FFFF_FFFC);
        addv(0, 0, 0, 1, 32'h0050_0093, 0, 0, 64'h8000_0400, 1, 32'h0050_0093, 64'h8000_0400);
        addv(0, 0, 0, 0, 32'h0,        1, 1, 64'h8000_0404, 0, 32'h0050_0093, 64'h8000_0400);
        addv(1, 64'h8000_0800, 0, 0, 32'h0, 0, 1, 64'h8000_0800, 0, 32'h0050_0093, 64'h8000_0400);

        do_reset();
        @(negedge clk);
        expect_out("reset", 1, RST_PC, 0, 32'h0, 64'h0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].rp, tbl[i].ry, tbl[i].rs, tbl[i].d, tbl[i].ir);
            expect_out($sformatf("vec%0d", i), tbl[i].erv, tbl[i].ea, tbl[i].eiv, tbl[i].ei, tbl[i].ep, 0);
        end

        // Misaligned redirect target
        step(1, 64'h8000_0002, 0, 0, 32'h0, 0);
        if (ALIGN) begin
            expect_out("align.req", 0, 64'h8000_0002, 0, 32'h0050_0093, 64'h8000_0400, 0);
            step(0, 0, 1, 0, 32'h0, 0);
            expect_out("align.hold", 0, 64'h8000_0002, 1, 32'h0, 64'h8000_0002, 1);
        end else begin
            expect_out("noalign.req", 1, 64'h8000_0002, 0, 32'h0050_0093, 64'h8000_0400, 0);
            step(0, 0, 1, 0, 32'h0, 0);
            expect_out("noalign.wait", 0, 64'h8000_0002, 0, 32'h0050_0093, 64'h8000_0400, 0);
        end

        // Reset while a fetch is outstanding; the late response must be ignored
        step(1, 64'h8000_1000, 0, 0, 32'h0, 0);
        step(0, 0, 1, 0, 32'h0, 0);
        chk("midrst.wait", {63'd0, req_valid}, 64'd0);
        do_reset();
        @(negedge clk);
        expect_out("midrst.reset", 1, RST_PC, 0, 32'h0, 64'h0, 0);
        step(0, 0, 0, 1, 32'h0000_0123, 0);
        expect_out("midrst.late", 1, RST_PC, 0, 32'h0, 64'h0, 0);
        step(0, 0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 32'h0000_0033, 0);
        expect_out("midrst.fetch", 0, RST_PC, 1, 32'h0000_0033, RST_PC, 0);

        // Randomized run against the reference model
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            bit          rd;
            logic [63:0] rp;
            rd = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       rp = {32'h8000_0000, 20'h0, 10'($urandom), 2'b00};
                1:       rp = 64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, 2'($urandom), 2'b00};
                2:       rp = {32'h8000_0000, 30'($urandom), 2'($urandom)};
                default: rp = {32'h8000_0000, 20'h0, 12'($urandom)} & ~64'h3;
            endcase
            step(rd, rp, 1'($urandom), ($urandom_range(0, 9) < 4), $urandom, 1'($urandom));
            expect_out($sformatf("rand%0d", c), m_req_valid(), m_pc, m_held, m_inst, m_ipc,
                       ALIGN ? m_fault : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
